// File: rtl/doorlock_disp_if.sv
// Keypad/verifier strobes in, panel pins and status out, for doorlock_disp_ctrl.
interface doorlock_disp_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       clr;
  logic       unlock;
  logic       fail;
  logic [1:0] mode;
  logic [2:0] entry_cnt;
  logic       com5, com6, com7, com8;
  logic       a, b, c, d, e, f, g;

  modport master (
    output key_valid, key_code, clr, unlock, fail,
    input  mode, entry_cnt, com5, com6, com7, com8, a, b, c, d, e, f, g
  );

  modport slave (
    input  key_valid, key_code, clr, unlock, fail,
    output mode, entry_cnt, com5, com6, com7, com8, a, b, c, d, e, f, g
  );
endinterface

// File: rtl/doorlock_disp_ctrl.sv
// Doorlock 4-digit 7-segment display controller: digit scan, entry buffer,
// and ENTRY/OPEN/ERR mode sequencing with timed holds.
module doorlock_disp_ctrl #(
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned OPEN_FRAMES = 500,
  parameter int unsigned ERR_FRAMES  = 500,
  parameter int unsigned BLINK_BIT   = 5
) (
  input logic           clk,
  input logic           rst,
  doorlock_disp_if.slave bus
);

  localparam int unsigned MAX_HOLD   = (OPEN_FRAMES > ERR_FRAMES) ? OPEN_FRAMES : ERR_FRAMES;
  localparam int unsigned BLINK_SPAN = 1 << (BLINK_BIT + 1);
  localparam int unsigned MAX_FRAME  = (MAX_HOLD > BLINK_SPAN) ? MAX_HOLD : BLINK_SPAN;
  localparam int unsigned FW         = $clog2(MAX_FRAME + 1);
  localparam int unsigned DW         = $clog2(SCAN_DIV);

  // Segment bit order: {a,b,c,d,e,f,g}
  localparam logic [6:0] G_O = 7'h7E;
  localparam logic [6:0] G_P = 7'h67;
  localparam logic [6:0] G_E = 7'h4F;
  localparam logic [6:0] G_N = 7'h76;
  localparam logic [6:0] G_R = 7'h05;

  typedef enum logic [1:0] {
    MODE_ENTRY = 2'd0,
    MODE_OPEN  = 2'd1,
    MODE_ERR   = 2'd2
  } mode_e;

  mode_e          mode_q, mode_d;
  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     sel_q, sel_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [15:0]    buf_q, buf_d;
  logic [6:0]     seg_q, seg_d;
  logic           slot_tick, frame_tick;
  logic [3:0]     com_oh;
  logic [3:0]     nib;

  function automatic logic [6:0] digit_glyph(input logic [3:0] dig);
    case (dig)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_ENTRY;
      div_q   <= '0;
      sel_q   <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      seg_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      seg_q   <= seg_d;
    end
  end

  // Next state: free-running scan plus mode/entry sequencing
  always_comb begin
    slot_tick  = (div_q == DW'(SCAN_DIV - 1));
    frame_tick = slot_tick && (sel_q == 2'd3);
    div_d      = slot_tick ? '0 : div_q + 1'b1;
    sel_d      = slot_tick ? sel_q + 2'd1 : sel_q;
    mode_d     = mode_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;

    case (mode_q)
      MODE_ENTRY: begin
        if (bus.fail || bus.unlock) begin
          mode_d  = bus.fail ? MODE_ERR : MODE_OPEN;
          cnt_d   = '0;
          buf_d   = '0;
          frame_d = '0;
        end else if (bus.clr) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (bus.key_valid && (bus.key_code <= 4'd9) && (cnt_q < 3'd4)) begin
          buf_d = {buf_q[11:0], bus.key_code};
          cnt_d = cnt_q + 3'd1;
        end
      end
      MODE_OPEN: begin
        if (frame_tick) begin
          if (frame_q == FW'(OPEN_FRAMES - 1)) begin
            mode_d  = MODE_ENTRY;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      MODE_ERR: begin
        if (frame_tick) begin
          if (frame_q == FW'(ERR_FRAMES - 1)) begin
            mode_d  = MODE_ENTRY;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: begin
        mode_d  = MODE_ENTRY;
        frame_d = '0;
      end
    endcase
  end

  // Outputs: segments are registered against sel_d so they switch on the
  // same edge as the com lines, while mode/buffer changes show one edge later.
  always_comb begin
    com_oh = 4'b0001 << sel_q;
    seg_d  = '0;
    case (sel_d)
      2'd0:    nib = buf_q[15:12];
      2'd1:    nib = buf_q[11:8];
      2'd2:    nib = buf_q[7:4];
      default: nib = buf_q[3:0];
    endcase
    case (mode_q)
      MODE_ENTRY: begin
        if (({1'b0, sel_d} + cnt_q) >= 3'd4) seg_d = digit_glyph(nib);
      end
      MODE_OPEN: begin
        case (sel_d)
          2'd0:    seg_d = G_O;
          2'd1:    seg_d = G_P;
          2'd2:    seg_d = G_E;
          default: seg_d = G_N;
        endcase
      end
      MODE_ERR: begin
        if (!frame_q[BLINK_BIT]) begin
          case (sel_d)
            2'd0:    seg_d = G_E;
            2'd1:    seg_d = G_R;
            2'd2:    seg_d = G_R;
            default: seg_d = '0;
          endcase
        end
      end
      default: seg_d = '0;
    endcase
  end

  assign bus.mode      = mode_q;
  assign bus.entry_cnt = cnt_q;
  assign bus.com5      = com_oh[0];
  assign bus.com6      = com_oh[1];
  assign bus.com7      = com_oh[2];
  assign bus.com8      = com_oh[3];
  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;

endmodule

// File: tb/tb_doorlock_disp_ctrl.sv
// Self-checking bench for doorlock_disp_ctrl: directed table, corner sequences
// and random strobes against a behavioural model of the panel.
module tb_doorlock_disp_ctrl;
  localparam int SD = 4;
  localparam int OF = 3;
  localparam int EF = 4;
  localparam int BB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  doorlock_disp_if bus ();

  doorlock_disp_ctrl #(
    .SCAN_DIV(SD),
    .OPEN_FRAMES(OF),
    .ERR_FRAMES(EF),
    .BLINK_BIT(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  string DIG[10]   = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  string OPEN_S[4] = '{"abcdef", "abefg", "adefg", "abcef"};
  string ERR_S[4]  = '{"adefg", "eg", "eg", ""};

  // Model state: edges since reset, mode number, entered digits (oldest first), frames held
  int unsigned cyc;
  int m_mode;
  int digits[$];
  int m_frame;
  int m_slot;
  logic [6:0] m_segs;

  typedef struct {
    bit kv;
    int kc;
    bit cl;
    bit un;
    bit fl;
    int exp_mode;
    int exp_cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [6:0] segs_of(input string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] model_segs(input int slot);
    int n;
    case (m_mode)
      0: begin
        n = digits.size();
        if (slot >= 4 - n) return segs_of(DIG[digits[slot - (4 - n)]]);
        return 7'h00;
      end
      1: return segs_of(OPEN_S[slot]);
      default: begin
        if (((m_frame >> BB) & 1) == 0) return segs_of(ERR_S[slot]);
        return 7'h00;
      end
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_mode = 0;
    digits.delete();
    m_frame = 0;
    m_slot = 0;
    m_segs = '0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit cl, input bit un, input bit fl);
    bit frame_end;
    m_slot = ((cyc + 1) / SD) % 4;
    m_segs = model_segs(m_slot);
    frame_end = (((cyc + 1) % (4 * SD)) == 0);
    case (m_mode)
      0: begin
        if (fl || un) begin
          m_mode = fl ? 2 : 1;
          digits.delete();
          m_frame = 0;
        end else if (cl) begin
          digits.delete();
        end else if (kv && kc <= 9 && digits.size() < 4) begin
          digits.push_back(kc);
        end
      end
      default: begin
        if (frame_end) begin
          m_frame++;
          if (m_frame == ((m_mode == 1) ? OF : EF)) begin
            m_mode = 0;
            m_frame = 0;
          end
        end
      end
    endcase
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic check_outputs();
    chk("mode", int'(bus.mode), m_mode);
    chk("entry_cnt", int'(bus.entry_cnt), digits.size());
    chk("com", int'({bus.com5, bus.com6, bus.com7, bus.com8}), int'(4'b1000 >> m_slot));
    chk("segs", int'({bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}), int'(m_segs));
  endtask

  // Drive strobes for one edge, advance the model, sample 1 ns after the edge
  task automatic tick_check(input bit kv, input int kc, input bit cl, input bit un, input bit fl);
    bus.key_valid = kv;
    bus.key_code  = 4'(kc);
    bus.clr       = cl;
    bus.unlock    = un;
    bus.fail      = fl;
    @(posedge clk);
    model_step(kv, kc, cl, un, fl);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_check(0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.clr       = 1'b0;
    bus.unlock    = 1'b0;
    bus.fail      = 1'b0;

    tbl[0]  = '{1, 1,  0, 0, 0, 0, 1};
    tbl[1]  = '{1, 2,  0, 0, 0, 0, 2};
    tbl[2]  = '{1, 3,  0, 0, 0, 0, 3};
    tbl[3]  = '{1, 4,  0, 0, 0, 0, 4};
    tbl[4]  = '{1, 5,  0, 0, 0, 0, 4};
    tbl[5]  = '{1, 12, 0, 0, 0, 0, 4};
    tbl[6]  = '{0, 0,  1, 0, 0, 0, 0};
    tbl[7]  = '{1, 7,  0, 0, 0, 0, 1};
    tbl[8]  = '{1, 9,  0, 0, 0, 0, 2};
    tbl[9]  = '{1, 6,  1, 0, 0, 0, 0};
    tbl[10] = '{1, 7,  0, 0, 0, 0, 1};
    tbl[11] = '{1, 9,  0, 0, 0, 0, 2};

    #2;
    chk("rst_com", int'({bus.com5, bus.com6, bus.com7, bus.com8}), 8);
    chk("rst_segs", int'({bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}), 0);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_cnt", int'(bus.entry_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Scan sequence with no strobes
    idle(32);

    // After four keys the panel holds 1,2,3,4 left to right
    for (int i = 0; i < 12; i++) begin
      tick_check(tbl[i].kv, tbl[i].kc, tbl[i].cl, tbl[i].un, tbl[i].fl);
      chk($sformatf("tbl%0d_mode", i), int'(bus.mode), tbl[i].exp_mode);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.entry_cnt), tbl[i].exp_cnt);
      idle(2);
      if (i == 3) idle(16);
    end
    idle(16);

    // Unlock, OPEN hold for three frame ticks, then blank ENTRY
    tick_check(0, 0, 0, 1, 0);
    chk("unlock_mode", int'(bus.mode), 1);
    chk("unlock_cnt", int'(bus.entry_cnt), 0);
    idle(56);
    chk("open_done_mode", int'(bus.mode), 0);

    // unlock+fail together goes to ERR; keys during ERR are ignored
    tick_check(1, 4, 0, 0, 0);
    tick_check(1, 2, 0, 0, 0);
    tick_check(0, 0, 0, 1, 1);
    chk("failsafe_mode", int'(bus.mode), 2);
    for (int i = 0; i < 40; i++) tick_check(1, $urandom_range(0, 9), i[0], 0, 0);
    chk("err_hold_cnt", int'(bus.entry_cnt), 0);
    idle(36);
    chk("err_done_mode", int'(bus.mode), 0);

    // Asynchronous reset in the middle of OPEN
    tick_check(1, 8, 0, 0, 0);
    tick_check(0, 0, 0, 1, 0);
    idle(9);
    #2 rst = 1'b1;
    #1;
    chk("async_com", int'({bus.com5, bus.com6, bus.com7, bus.com8}), 8);
    chk("async_segs", int'({bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}), 0);
    chk("async_mode", int'(bus.mode), 0);
    chk("async_cnt", int'(bus.entry_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(20);

    // Random strobe mix
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)      tick_check(1, $urandom_range(0, 15), 0, 0, 0);
      else if (r < 54) tick_check(0, 0, 1, 0, 0);
      else if (r < 56) tick_check(1, $urandom_range(0, 9), 1, 0, 0);
      else if (r < 58) tick_check(0, 0, 0, 1, 0);
      else if (r < 60) tick_check(0, 0, 0, 0, 1);
      else if (r < 61) tick_check(1, $urandom_range(0, 9), 1, 1, 1);
      else             tick_check(0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/doorlock_disp_ctrl.md
Name: doorlock_disp_ctrl

Overview:
Display controller for the doorlock's 4-digit common-select 7-segment panel. Owns the digit-scan sequencing and the mode sequencing for the panel:
- ENTRY: shows the digits keyed in, right-aligned.
- OPEN: shows "OPEN" for a timed hold.
- ERR: shows a blinking "Err" for a timed hold.
Sits between the keypad/verify logic and the panel pins (com5..com8, a..g).

Parameters:
- SCAN_DIV, 25000, clk cycles per digit slot (>=2).
- OPEN_FRAMES, 500, scan frames (4 slots each) OPEN is held.
- ERR_FRAMES, 500, scan frames ERR is held.
- BLINK_BIT, 5, frame-counter bit that gates ERR blink (0 = lit).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- key_valid, in, 1, one-cycle strobe: key_code is valid.
- key_code, in, 4, keypad digit 0..9; 10..15 are ignored.
- clr, in, 1, one-cycle strobe: clear the entry buffer.
- unlock, in, 1, one-cycle strobe from verifier: code accepted.
- fail, in, 1, one-cycle strobe from verifier: code rejected.
- mode, out, 2, current state: 0=ENTRY, 1=OPEN, 2=ERR.
- entry_cnt, out, 3, number of digits entered (0..4).
- com5/com6/com7/com8, out, 1 each, digit selects, active-high, one-hot; com5 is leftmost.
- a, b, c, d, e, f, g, out, 1 each, segments, active-high.

Behaviour:
- Clock and reset: one clock domain; all state clears on rst asynchronously.
- Reset values: div_cnt=0, sel=0, frame_cnt=0, mode=ENTRY, entry_cnt=0, buffer=0. Outputs: com5=1, com6..com8=0, a..g=0.
- Scan prescaler:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - slot_tick is asserted when div_cnt==SCAN_DIV-1.
  - sel (2 bits) increments on slot_tick, wrapping 3->0.
  - frame_tick = slot_tick && sel==3.
- Digit selects: com5..com8 = one-hot decode of sel 0..3. Exactly one is high at all times. The scan never stops and is never reset by mode changes.
- Segment timing: segments are a registered function of (mode, sel, buffer, frame_cnt) and change on the same edge as the com outputs (no skew cycle).
- Glyphs (segments lit):
  - Digits: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
  - Letters: O=abcdef, P=abefg, E=adefg, N=abcef, r=eg.
  - blank = none.
- ENTRY mode display:
  - Slot sel shows buffer digit (sel-(4-entry_cnt)) when sel >= 4-entry_cnt; otherwise blank.
  - The newest digit is always in slot 3 (com8).
- OPEN mode display: slots 0..3 = O, P, E, N.
- ERR mode display:
  - Slots 0..3 = E, r, r, blank, shown while frame_cnt[BLINK_BIT]==0.
  - All slots are blank while frame_cnt[BLINK_BIT]==1.
- Entry buffer (ENTRY mode only):
  - key_valid with key_code<=9 and entry_cnt<4: shift the buffer left, insert key_code as the newest digit, entry_cnt+1.
  - entry_cnt==4 (saturated): the key is ignored and the buffer is unchanged.
  - key_code>9: the key is ignored.
  - clr: entry_cnt=0 and buffer=0.
- FSM transitions:
  - ENTRY, fail -> ERR. ENTRY, unlock -> OPEN. On either transition: buffer cleared, entry_cnt=0, frame_cnt=0.
  - OPEN: frame_cnt increments on frame_tick. When frame_cnt reaches OPEN_FRAMES -> ENTRY with frame_cnt=0.
  - ERR: same as OPEN, using ERR_FRAMES.
  - In OPEN/ERR, key_valid, clr, unlock and fail are all ignored.
- Priority within one cycle, in ENTRY:
  - fail > unlock > clr > key_valid.
  - unlock and fail together -> ERR (fail-safe).
  - clr and key_valid together -> buffer cleared, key dropped.
- Latency: mode and entry_cnt update on the edge after the strobe. The display reflects the new state on the following edge.
- Widths: frame_cnt is wide enough for max(OPEN_FRAMES, ERR_FRAMES, 2^(BLINK_BIT+1)). No arithmetic overflow is permitted.
- Reset mid-OPEN/ERR: returns to ENTRY immediately (asynchronously), with all counters cleared.

Test Plan:
1. SCAN_DIV=4, reset then idle 32 cycles -> com5 high for cycles 0-3, com6 4-7, com7 8-11, com8 12-15, then repeat; a..g=0 throughout; mode=0, entry_cnt=0.
2. Keys 1,2,3,4,5, clocks spaced -> entry_cnt 1,2,3,4,4. Slots show 1,2,3,4 (com5 segs=bc ... com8 segs=bcfg); the 5 is dropped. Key_code 12 -> no change.
3. Two keys (7,9) then unlock -> mode=1, entry_cnt=0. With OPEN_FRAMES=3: slots show abcdef, abefg, adefg, abcef. mode returns to 0 exactly at the 3rd frame_tick; the panel is then blank.
4. unlock and fail asserted together in ENTRY -> mode=2. With BLINK_BIT=0: frames alternate E,r,r,blank / all blank. With ERR_FRAMES=4: key_valid during ERR is ignored, and mode=0 after the 4th frame_tick.
5. clr and key_valid (key 6) together with entry_cnt=2 -> entry_cnt=0; panel blank.
6. rst asserted mid-OPEN, asynchronously between edges -> com5=1, a..g=0, mode=0 without waiting for a clock edge; after release the scan restarts at sel=0.
